// File: rtl/sad_min_tracker.sv
// sad_min_tracker: tracks the minimum SAD and its index over a search; optional SAD_TIE_LATEST_EN makes the latest equal candidate win
module sad_min_tracker #(
  parameter int VALUE_W = 14,
  parameter int INDEX_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inValid,
  input  logic [VALUE_W-1:0] inValue,
  input  logic [INDEX_W-1:0] inIndex,
  input  logic               inTriggerBoss,
  output logic               inReady,
  output logic               outValid,
  input  logic               outReady,
  output logic [VALUE_W-1:0] bestValue,
  output logic [INDEX_W-1:0] bestIndex,
  output logic [15:0]        candCount,
  output logic               dropErr
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t             state_q, state_d;
  logic [VALUE_W-1:0] best_value_q, best_value_d;
  logic [INDEX_W-1:0] best_index_q, best_index_d;
  logic [15:0]        cand_count_q, cand_count_d;
  logic               drop_err_q, drop_err_d;
  logic               accept, better;
  assign inReady   = state_q != HOLD;
  assign outValid  = state_q == HOLD;
  assign accept    = inValid && inReady;
  assign bestValue = best_value_q;
  assign bestIndex = best_index_q;
  assign candCount = cand_count_q;
  assign dropErr   = drop_err_q;
`ifdef SAD_TIE_LATEST_EN
  assign better = inValue <= best_value_q;
`else
  assign better = inValue < best_value_q;
`endif
  // next state: first accept loads, later accepts compare, trigger closes the search, handshake frees the result
  always_comb begin
    state_d      = state_q;
    best_value_d = best_value_q;
    best_index_d = best_index_q;
    cand_count_d = cand_count_q;
    drop_err_d   = drop_err_q || (inValid && !inReady);
    if (accept) begin
      if (state_q == IDLE || better) begin
        best_value_d = inValue;
        best_index_d = inIndex;
      end
      cand_count_d = state_q == IDLE ? 16'd1 :
                     cand_count_q == 16'hFFFF ? cand_count_q : cand_count_q + 16'd1;
      state_d      = inTriggerBoss ? HOLD : ACCUM;
    end else if (state_q == HOLD && outReady) begin
      state_d = IDLE;
    end
  end
  // state register with synchronous reset discarding any open or held search
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      best_value_q <= '0;
      best_index_q <= '0;
      cand_count_q <= '0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      best_value_q <= best_value_d;
      best_index_q <= best_index_d;
      cand_count_q <= cand_count_d;
      drop_err_q   <= drop_err_d;
    end
  end
endmodule

// File: tb/tb_sad_min_tracker.sv
// tb_sad_min_tracker: scoreboard bench for sad_min_tracker
module tb_sad_min_tracker;
  typedef struct packed {
    logic [13:0] value;
    logic [15:0] index;
    logic [15:0] count;
  } res_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic [13:0] inValue = '0;
  logic [15:0] inIndex = '0;
  logic        inTriggerBoss = 1'b0;
  logic        inReady, outValid;
  logic        outReady = 1'b1;
  logic [13:0] bestValue;
  logic [15:0] bestIndex, candCount;
  logic        dropErr;
  int          n_cmp = 0;
  int          n_err = 0;
  res_t        exp_q[$];
  res_t        r;
  sad_min_tracker dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inValue(inValue), .inIndex(inIndex),
    .inTriggerBoss(inTriggerBoss), .inReady(inReady), .outValid(outValid), .outReady(outReady),
    .bestValue(bestValue), .bestIndex(bestIndex), .candCount(candCount), .dropErr(dropErr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [13:0] v, input logic [15:0] i, input logic [15:0] c);
    res_t e;
    e.value = v;
    e.index = i;
    e.count = c;
    exp_q.push_back(e);
  endtask
  task automatic drive(input logic [13:0] v, input logic [15:0] i, input logic t);
    inValid = 1'b1;
    inValue = v;
    inIndex = i;
    inTriggerBoss = t;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inTriggerBoss = 1'b0;
    if (t) chk("latency", outValid, 1);
    if (t && outReady) begin
      @(posedge clk);
      #1;
      chk("hs_idle", outValid, 0);
    end
  endtask
  task automatic bubbles(input int n);
    inValid = 1'b0;
    inValue = '0;
    inTriggerBoss = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    inTriggerBoss = 1'b0;
    chk("bubble_no_out", outValid, 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (outValid && outReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        r = exp_q.pop_front();
        chk("bestValue", bestValue, r.value);
        chk("bestIndex", bestIndex, r.index);
        chk("candCount", candCount, r.count);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outValid", outValid, 0);
    chk("rst_bestValue", bestValue, 0);
    chk("rst_bestIndex", bestIndex, 0);
    chk("rst_candCount", candCount, 0);
    chk("rst_dropErr", dropErr, 0);
    chk("rst_inReady", inReady, 1);
    rst = 1'b0;
`ifdef SAD_TIE_LATEST_EN
    push(14'd20, 16'd3, 16'd4);
`else
    push(14'd20, 16'd1, 16'd4);
`endif
    drive(14'd50, 16'd0, 1'b0);
    drive(14'd20, 16'd1, 1'b0);
    drive(14'd35, 16'd2, 1'b0);
    drive(14'd20, 16'd3, 1'b1);
    push(14'h3FFF, 16'd7, 16'd1);
    drive(14'h3FFF, 16'd7, 1'b1);
    push(14'd4, 16'd11, 16'd3);
    drive(14'd9, 16'd10, 1'b0);
    bubbles(2);
    drive(14'd4, 16'd11, 1'b0);
    bubbles(3);
    drive(14'd6, 16'd12, 1'b1);
    outReady = 1'b0;
    push(14'd3, 16'd21, 16'd2);
    drive(14'd5, 16'd20, 1'b0);
    drive(14'd3, 16'd21, 1'b1);
    for (int k = 0; k < 5; k++) begin
      inValid = 1'b1;
      inValue = 14'd1;
      inIndex = 16'd99;
      inTriggerBoss = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_inReady", inReady, 0);
      chk("hold_outValid", outValid, 1);
      chk("hold_bestValue", bestValue, 3);
      chk("hold_bestIndex", bestIndex, 21);
      chk("hold_candCount", candCount, 2);
      chk("hold_dropErr", dropErr, 1);
    end
    inValid = 1'b0;
    inTriggerBoss = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    chk("release_outValid", outValid, 0);
    chk("release_inReady", inReady, 1);
    push(14'd7, 16'd30, 16'd1);
    drive(14'd7, 16'd30, 1'b1);
    drive(14'd10, 16'd40, 1'b0);
    drive(14'd11, 16'd41, 1'b0);
    drive(14'd1, 16'd42, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_outValid", outValid, 0);
    chk("mid_rst_bestValue", bestValue, 0);
    chk("mid_rst_bestIndex", bestIndex, 0);
    chk("mid_rst_candCount", candCount, 0);
    chk("mid_rst_dropErr", dropErr, 0);
    chk("mid_rst_inReady", inReady, 1);
    push(14'd2, 16'd51, 16'd2);
    drive(14'd8, 16'd50, 1'b0);
    drive(14'd2, 16'd51, 1'b1);
    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sad_min_tracker.md
SAD_MIN_TRACKER -- requirements
Module: sad_min_tracker

Interface
REQ-001 The block SHALL have parameter VALUE_W, default 14, the SAD value width.
REQ-002 The block SHALL have parameter INDEX_W, default 16, the candidate index width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port inValid, input, 1 bit, marking a valid SAD candidate this cycle.
REQ-006 The block SHALL have port inValue, input, VALUE_W bits, the candidate SAD.
REQ-007 The block SHALL have port inIndex, input, INDEX_W bits, the candidate position index.
REQ-008 The block SHALL have port inTriggerBoss, input, 1 bit, marking the last candidate of a search.
REQ-009 The block SHALL have port inReady, output, 1 bit, high when a candidate can be accepted.
REQ-010 The block SHALL have port outValid, output, 1 bit, high while a search result is held.
REQ-011 The block SHALL have port outReady, input, 1 bit, consumer acceptance of the result.
REQ-012 The block SHALL have port bestValue, output, VALUE_W bits, the minimum SAD of the search.
REQ-013 The block SHALL have port bestIndex, output, INDEX_W bits, the index of the minimum SAD.
REQ-014 The block SHALL have port candCount, output, 16 bits, the number of candidates accepted in the search.
REQ-015 The block SHALL have port dropErr, output, 1 bit, a sticky flag for a candidate offered while inReady=0.

Function
REQ-016 An accept SHALL be a cycle with inValid=1 and inReady=1; cycles with inValid=0 are bubbles and change no state.
REQ-017 The FSM SHALL have states IDLE (no candidate), ACCUM (search open) and HOLD (result pending).
REQ-018 inReady SHALL be 1 in IDLE and ACCUM and 0 in HOLD; it is a combinational decode of the state only.
REQ-019 On an accept in IDLE, the block SHALL load bestValue/bestIndex unconditionally, set candCount=1, and move to HOLD if inTriggerBoss=1, else to ACCUM.
REQ-020 On an accept in ACCUM, the block SHALL replace bestValue/bestIndex when inValue < bestValue (unsigned, strict).
REQ-021 On an accept in ACCUM, candCount SHALL increment, saturating at 16'hFFFF.
REQ-022 On an accept in ACCUM, the block SHALL move to HOLD if inTriggerBoss=1.
REQ-023 The trigger candidate SHALL take part in the comparison, and outValid SHALL assert the cycle after it is accepted (latency 1).
REQ-024 In HOLD, outValid SHALL be 1, and bestValue, bestIndex and candCount SHALL be stable until the handshake.
REQ-025 In HOLD, outValid=1 with outReady=1 SHALL complete the handshake: next state IDLE, outValid=0.
REQ-026 In HOLD, the block SHALL not accept a new candidate in the same cycle as the handshake.
REQ-027 An offer (inValid=1) in HOLD SHALL be discarded and SHALL set dropErr; dropErr clears only on rst.
REQ-028 In IDLE or ACCUM, bestValue, bestIndex and candCount SHALL show the running state and are defined only while outValid=1.
REQ-029 An inValue of all-ones SHALL be a legal candidate; a single-candidate search SHALL return that candidate.

Reset
REQ-030 rst SHALL force state=IDLE and set outValid=0, bestValue=0, bestIndex=0, candCount=0 and dropErr=0.
REQ-031 rst SHALL take priority over every other event, and an open or held search SHALL be discarded without a handshake.

Configuration
REQ-032 With macro SAD_TIE_LATEST_EN defined, the ACCUM compare SHALL be inValue <= bestValue, so the latest equal candidate wins.
REQ-033 Without SAD_TIE_LATEST_EN, the strict compare of REQ-020 SHALL apply, so the earliest equal candidate wins.

Verification
REQ-034 The bench SHALL drive values 50,20,35,20(trigger) at indices 0..3 with outReady=1 -> outValid one cycle after the trigger; bestValue=20, bestIndex=1 (3 with SAD_TIE_LATEST_EN), candCount=4.
REQ-035 The bench SHALL drive a single candidate 0x3FFF, index 7, with trigger -> bestValue=0x3FFF, bestIndex=7, candCount=1, next cycle.
REQ-036 The bench SHALL insert bubbles between candidates 9,4,6(trigger) -> bubbles ignored; bestValue=4, candCount=3.
REQ-037 The bench SHALL hold outReady=0 for 5 cycles after a result and offer candidates meanwhile -> outputs stable, inReady=0, dropErr=1; outReady=1 -> IDLE; the next search is unaffected.
REQ-038 The bench SHALL assert rst mid-ACCUM after 3 candidates -> next cycle IDLE with all outputs 0; a following search of 8,2(trigger) -> bestValue=2, candCount=2.
